// File: rtl/ps2_host_rx_if.sv
// ps2_host_rx_if: PS/2 line inputs and decoded key outputs of ps2_host_rx.
// Revision: 1.0
`default_nettype none

interface ps2_host_rx_if;
  logic       PS2C;
  logic       PS2D;
  logic [7:0] ps2_key_code;
  logic       key_strobe;
  logic       key_break;
  logic       frame_err;
  logic       parity_err;

  // master drives the PS/2 lines and consumes decoded keys; slave is the receiver
  modport master (
    output PS2C, PS2D,
    input  ps2_key_code, key_strobe, key_break, frame_err, parity_err
  );

  modport slave (
    input  PS2C, PS2D,
    output ps2_key_code, key_strobe, key_break, frame_err, parity_err
  );
endinterface

`default_nettype wire

// File: rtl/ps2_host_rx.sv
// ps2_host_rx: PS/2 keyboard receiver with clock filtering, timeout and break-code tagging.
// Revision: 1.0 -- define PS2_PARITY_CHECK_EN to enable odd-parity checking.
`default_nettype none

module ps2_host_rx #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 4
) (
  input  logic          ck,
  input  logic          reset,
  ps2_host_rx_if.slave  bus
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic          ps2c_s1, ps2c_s2;
  logic          ps2d_s1, ps2d_s2;
  logic [FW-1:0] filt_cnt;
  logic          filt;
  logic          filt_prev;
  logic          fall;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] to_cnt;
  logic          break_pending;
  logic [7:0]    key_code_q;
  logic          strobe_q;
  logic          break_q;
  logic          ferr_q;
`ifdef PS2_PARITY_CHECK_EN
  logic          par_bit;
  logic          perr_q;
`endif

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      ps2c_s1 <= 1'b1;
      ps2c_s2 <= 1'b1;
      ps2d_s1 <= 1'b1;
      ps2d_s2 <= 1'b1;
    end else begin
      ps2c_s1 <= bus.PS2C;
      ps2c_s2 <= ps2c_s1;
      ps2d_s1 <= bus.PS2D;
      ps2d_s2 <= ps2d_s1;
    end
  end

  // Filtered level flips only after FILTER_LEN consecutive samples disagree with it
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      filt_cnt  <= '0;
      filt      <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      filt_prev <= filt;
      if (ps2c_s2 != filt) begin
        if (filt_cnt == FILT_LAST) begin
          filt     <= ps2c_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall = filt_prev & ~filt;

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shreg         <= '0;
      to_cnt        <= '0;
      break_pending <= 1'b0;
      key_code_q    <= '0;
      strobe_q      <= 1'b0;
      break_q       <= 1'b0;
      ferr_q        <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit       <= 1'b0;
      perr_q        <= 1'b0;
`endif
    end else begin
      strobe_q <= 1'b0;
      break_q  <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      perr_q   <= 1'b0;
`endif
      // An edge always takes priority over an expiring timeout
      if (fall) begin
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (!ps2d_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              ferr_q <= 1'b1;
            end
          end
          DATA: begin
            shreg   <= {ps2d_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= ps2d_s2;
`endif
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!ps2d_s2) begin
              ferr_q <= 1'b1;
            end
`ifdef PS2_PARITY_CHECK_EN
            else if (^{shreg, par_bit} == 1'b0) begin
              perr_q <= 1'b1;
            end
`endif
            else begin
              key_code_q <= shreg;
              strobe_q   <= 1'b1;
              // 0xF0 is a break prefix: report it plainly and tag the following byte
              if (shreg == 8'hF0) begin
                break_q       <= 1'b0;
                break_pending <= 1'b1;
              end else begin
                break_q       <= break_pending;
                break_pending <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (to_cnt == TO_LAST) begin
          ferr_q <= 1'b1;
          state  <= IDLE;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.ps2_key_code = key_code_q;
  assign bus.key_strobe   = strobe_q;
  assign bus.key_break    = break_q;
  assign bus.frame_err    = ferr_q;
`ifdef PS2_PARITY_CHECK_EN
  assign bus.parity_err   = perr_q;
`else
  assign bus.parity_err   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_rx.sv
// tb_ps2_host_rx: directed frames against ps2_host_rx with hand-computed expectations.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_host_rx;

  localparam int HALF = 8;

  logic ck;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  int         n_strobe = 0;
  int         n_ferr   = 0;
  int         n_perr   = 0;
  logic [7:0] last_code = 8'h00;
  logic       last_brk  = 1'b0;
  int         bs, bf, bp;

  ps2_host_rx_if bus ();

  ps2_host_rx dut (
    .ck    (ck),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  always @(negedge ck) begin
    if (bus.key_strobe) begin
      n_strobe  = n_strobe + 1;
      last_code = bus.ps2_key_code;
      last_brk  = bus.key_break;
    end
    if (bus.frame_err)  n_ferr = n_ferr + 1;
    if (bus.parity_err) n_perr = n_perr + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  task automatic snap();
    bs = n_strobe;
    bf = n_ferr;
    bp = n_perr;
  endtask

  task automatic glitch();
    wait_cyc(1);
    bus.PS2C = 1'b0;
    wait_cyc(2);
    bus.PS2C = 1'b1;
  endtask

  task automatic ps2_bit(input logic b);
    bus.PS2D = b;
    wait_cyc(HALF);
    bus.PS2C = 1'b0;
    wait_cyc(HALF);
    bus.PS2C = 1'b1;
    wait_cyc(HALF);
  endtask

  // Sends the first nbits of {stop, parity, data, start}, LSB first
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stp,
                            input int nbits, input int glitch_at);
    logic [10:0] f;
    f = {stp, par, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch_at) glitch();
      ps2_bit(f[i]);
    end
    bus.PS2D = 1'b1;
    wait_cyc(30);
  endtask

  initial begin
    reset    = 1'b1;
    bus.PS2C = 1'b1;
    bus.PS2D = 1'b1;
    #23;
    check("rst_code",   {24'h0, bus.ps2_key_code}, 32'h00);
    check("rst_strobe", {31'h0, bus.key_strobe},   32'h0);
    check("rst_break",  {31'h0, bus.key_break},    32'h0);
    check("rst_ferr",   {31'h0, bus.frame_err},    32'h0);
    check("rst_perr",   {31'h0, bus.parity_err},   32'h0);
    @(negedge ck);
    reset = 1'b0;
    wait_cyc(10);

    // 0x69, odd parity bit 1
    snap();
    send_frame(8'h69, 1'b1, 1'b1, 11, -1);
    check("x69_nstrobe", n_strobe - bs, 1);
    check("x69_code",    {24'h0, last_code}, 32'h69);
    check("x69_break",   {31'h0, last_brk},  32'h0);
    check("x69_ferr",    n_ferr - bf, 0);

    // Break sequence F0, 69, then a plain 69
    snap();
    send_frame(8'hF0, 1'b1, 1'b1, 11, -1);
    check("xf0_nstrobe", n_strobe - bs, 1);
    check("xf0_code",    {24'h0, last_code}, 32'hF0);
    check("xf0_break",   {31'h0, last_brk},  32'h0);
    send_frame(8'h69, 1'b1, 1'b1, 11, -1);
    check("brk69_code",  {24'h0, last_code}, 32'h69);
    check("brk69_break", {31'h0, last_brk},  32'h1);
    send_frame(8'h69, 1'b1, 1'b1, 11, -1);
    check("post69_break", {31'h0, last_brk}, 32'h0);
    check("brkseq_nstrobe", n_strobe - bs, 3);

    // 2-cycle PS2C glitch inside frame 0x1C (parity 0) must not consume a bit
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 11, 4);
    check("glitch_nstrobe", n_strobe - bs, 1);
    check("glitch_code",    {24'h0, bus.ps2_key_code}, 32'h1C);
    check("glitch_ferr",    n_ferr - bf, 0);

    // 0x69 with wrong parity bit
    snap();
    send_frame(8'h69, 1'b0, 1'b1, 11, -1);
`ifdef PS2_PARITY_CHECK_EN
    check("par_nperr",    n_perr - bp, 1);
    check("par_nstrobe",  n_strobe - bs, 0);
    check("par_code",     {24'h0, bus.ps2_key_code}, 32'h1C);
`else
    check("par_nperr",    n_perr - bp, 0);
    check("par_nstrobe",  n_strobe - bs, 1);
    check("par_code",     {24'h0, bus.ps2_key_code}, 32'h69);
`endif
    check("par_ferr", n_ferr - bf, 0);

    // 0x7A with stop bit 0
    snap();
    send_frame(8'h7A, 1'b0, 1'b0, 11, -1);
    check("stop_nferr",    n_ferr - bf, 1);
    check("stop_nstrobe",  n_strobe - bs, 0);
    check("stop_nperr",    n_perr - bp, 0);

    // Clock stops after start + 4 data bits; frame times out
    snap();
    send_frame(8'h72, 1'b1, 1'b1, 5, -1);
    check("to_early_ferr", n_ferr - bf, 0);
    wait_cyc(50100);
    check("to_nferr",    n_ferr - bf, 1);
    check("to_nstrobe",  n_strobe - bs, 0);
    snap();
    send_frame(8'h72, 1'b1, 1'b1, 11, -1);
    check("after_to_nstrobe", n_strobe - bs, 1);
    check("after_to_code",    {24'h0, last_code}, 32'h72);
    check("after_to_ferr",    n_ferr - bf, 0);

    // Reset in the middle of DATA
    send_frame(8'h69, 1'b1, 1'b1, 4, -1);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_code",   {24'h0, bus.ps2_key_code}, 32'h00);
    check("midrst_strobe", {31'h0, bus.key_strobe},   32'h0);
    check("midrst_break",  {31'h0, bus.key_break},    32'h0);
    check("midrst_ferr",   {31'h0, bus.frame_err},    32'h0);
    wait_cyc(5);
    @(negedge ck);
    reset = 1'b0;
    wait_cyc(10);
    snap();
    send_frame(8'h69, 1'b1, 1'b1, 11, -1);
    check("postrst_nstrobe", n_strobe - bs, 1);
    check("postrst_code",    {24'h0, last_code}, 32'h69);
    check("postrst_break",   {31'h0, last_brk},  32'h0);
    check("postrst_ferr",    n_ferr - bf, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ps2_host_rx.md
PS2_HOST_RX -- requirements
Module: ps2_host_rx

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning ck cycles without a filtered PS2C falling edge before an in-progress frame is abandoned.
REQ-002 The block SHALL have parameter FILTER_LEN, default 4, meaning consecutive identical synchronized PS2C samples required to change the filtered clock level.
REQ-003 The block SHALL have port ck, input, 1 bit, the system clock; all logic is on posedge ck.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port PS2C, input, 1 bit, the PS2 clock from the keyboard, asynchronous to ck.
REQ-006 The block SHALL have port PS2D, input, 1 bit, the PS2 data from the keyboard, asynchronous to ck.
REQ-007 The block SHALL have port ps2_key_code, output, 8 bits, the last accepted byte, held until the next accepted byte.
REQ-008 The block SHALL have port key_strobe, output, 1 bit, a one-ck pulse when ps2_key_code updates.
REQ-009 The block SHALL have port key_break, output, 1 bit, asserted with key_strobe when the byte follows an accepted 0xF0.
REQ-010 The block SHALL have port frame_err, output, 1 bit, a one-ck pulse on a bad start bit, bad stop bit or timeout.
REQ-011 The block SHALL have port parity_err, output, 1 bit, a one-ck pulse on odd-parity mismatch.

Function
REQ-012 PS2C and PS2D SHALL each pass through a 2-flop synchronizer; PS2C SHALL then be filtered per FILTER_LEN; the filtered level SHALL reset to 1.
REQ-013 A falling edge SHALL be a filtered PS2C 1->0 transition, detected in one ck; synchronized PS2D SHALL be sampled on that same cycle.
REQ-014 The FSM SHALL have states IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: on an edge with PS2D=0, go to DATA with bit count 0; on an edge with PS2D=1, pulse frame_err and stay in IDLE.
REQ-016 DATA: shift in 8 bits LSB first, one per edge; after the 8th, go to PARITY.
REQ-017 PARITY: capture the bit and go to STOP.
REQ-018 STOP: on an edge with PS2D=1 and parity OK (or checking disabled), accept the byte; with PS2D=0, pulse frame_err, discard the byte and return to IDLE.
REQ-019 Accept SHALL mean: next ck ps2_key_code <= byte, key_strobe=1 for exactly one cycle, return to IDLE.
REQ-020 An accepted 0xF0 SHALL be output like any byte (key_break=0) and SHALL set break_pending.
REQ-021 The next accepted byte SHALL assert key_break with its key_strobe and clear break_pending; consecutive 0xF0 bytes SHALL keep break_pending set.
REQ-022 The timeout counter SHALL clear on every edge and count in non-IDLE states; at TIMEOUT_CYCLES it SHALL pulse frame_err, discard the partial byte, return to IDLE and leave break_pending unchanged.
REQ-023 If an edge and the timeout occur in the same cycle, the edge SHALL win.
REQ-024 Outputs other than ps2_key_code SHALL be registered pulses that are 0 in all other cycles; no two error pulses SHALL be produced for one frame.

Reset
REQ-025 Asserting reset SHALL immediately force state IDLE, ps2_key_code=0x00, key_strobe=0, key_break=0, frame_err=0, parity_err=0, break_pending=0, counters=0, synchronizers=1.
REQ-026 Reset mid-frame SHALL discard the partial byte; the first frame after release SHALL decode normally.

Configuration
REQ-027 With PS2_PARITY_CHECK_EN defined, an odd-parity mismatch SHALL pulse parity_err at STOP, discard the byte and leave break_pending unchanged.
REQ-028 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be sampled and ignored, and parity_err SHALL be tied to 0.

Verification
REQ-029 Frame 0x69 (parity 1) -> one key_strobe, ps2_key_code=0x69, key_break=0.
REQ-030 Frames 0xF0 then 0x69 -> strobe with 0xF0/key_break=0, then strobe with 0x69/key_break=1; a following 0x69 -> key_break=0.
REQ-031 Frame 0x69 with parity bit 0, macro defined -> parity_err pulse, no strobe, ps2_key_code unchanged; macro undefined -> strobe with 0x69.
REQ-032 PS2C stopped after 4 data bits for more than 50000 cycles -> one frame_err, IDLE; next full frame 0x72 -> strobe with 0x72.
REQ-033 Stop bit 0 on frame 0x7A -> frame_err, no strobe; 2-cycle PS2C glitch with FILTER_LEN=4 -> no bit consumed.
REQ-034 Reset asserted during DATA -> all outputs 0 immediately; frame 0x69 after release -> correct strobe.
